// File: rtl/uart_tx_device.sv
// Byte FIFO for the UART transmitter; a push into a full FIFO is accepted when a pop happens in the same cycle.
// Zero-latency read port (o_rd_dat shows the head); o_wr_rdy low means the pushed byte is dropped.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_vld,
  input  logic [W-1:0] i_wr_dat,
  output logic         o_wr_rdy,
  input  logic         i_rd_rdy,
  output logic [W-1:0] o_rd_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // Extra pointer bit tells a wrapped (full) FIFO from an empty one.
  assign o_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = i_rd_rdy && !o_empty;
  assign o_wr_rdy = !o_full || w_pop;
  assign w_push   = i_wr_vld && o_wr_rdy;
  assign o_rd_dat = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_dat;
  end
endmodule

// Memory-mapped 8N1 UART transmitter: DATA/STATUS/CTRL/DIV registers, byte FIFO, level IRQ on drain.
// Start bit begins one cycle after the first DATA write; frames run back-to-back; full-FIFO writes set ovf.
module uart_tx_device #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [7:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]  r_state;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_irq;
  logic        r_irq_en;
  logic        r_ovf;

  logic        w_wr_data;
  logic        w_wr_stat;
  logic        w_wr_ctrl;
  logic        w_wr_div;
  logic        w_fifo_rdy;
  logic [7:0]  w_fifo_dat;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_busy;
  logic        w_bit_end;
  logic [15:0] w_div_load;
  logic [15:0] w_bit_len;
  logic        w_unused;

  assign w_wr_data  = WE && (Addr[3:2] == 2'd0);
  assign w_wr_stat  = WE && (Addr[3:2] == 2'd1);
  assign w_wr_ctrl  = WE && (Addr[3:2] == 2'd2);
  assign w_wr_div   = WE && (Addr[3:2] == 2'd3);
  assign w_div_load = (Din[15:0] < 16'd2) ? 16'd2 : Din[15:0];
  assign w_bit_len  = r_div - 16'd1;
  assign w_busy     = (r_state != S_IDLE);
  assign w_bit_end  = (r_cnt == 16'd0);
  assign w_pop      = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end)) && !w_empty;
  assign w_unused   = ^{Addr[7:4], Addr[1:0], Din[31:16]};
  assign IRQ        = r_irq;
  assign txd        = r_txd;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .rst_n    (sys_rstn),
    .i_wr_vld (w_wr_data),
    .i_wr_dat (Din[7:0]),
    .o_wr_rdy (w_fifo_rdy),
    .i_rd_rdy (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Bit counter reloads from r_div only at bit boundaries, so a DIV write never stretches the current bit.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_START;
            r_shift <= w_fifo_dat;
            r_cnt   <= w_bit_len;
            r_txd   <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_bit   <= 3'd0;
            r_cnt   <= w_bit_len;
            r_txd   <= r_shift[0];
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (!w_bit_end) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (r_bit == 3'd7) begin
            r_state <= S_STOP;
            r_cnt   <= w_bit_len;
            r_txd   <= 1'b1;
          end else begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {1'b0, r_shift[7:1]};
            r_txd   <= r_shift[1];
            r_cnt   <= w_bit_len;
          end
        end
        S_STOP: begin
          if (!w_bit_end) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!w_empty) begin
            r_state <= S_START;
            r_shift <= w_fifo_dat;
            r_cnt   <= w_bit_len;
            r_txd   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= 16'(BAUD_DIV);
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_data && !w_fifo_rdy) r_ovf <= 1'b1;
      else if (w_wr_stat && Din[4]) r_ovf <= 1'b0;
      if (w_wr_ctrl) r_irq_en <= Din[0];
      if (w_wr_div)  r_div    <= w_div_load;
      r_irq <= r_irq_en && w_empty && !w_busy;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'd1:    Dout = {27'd0, r_ovf, r_irq_en, w_busy, w_full, w_empty};
      2'd2:    Dout = {31'd0, r_irq_en};
      2'd3:    Dout = {16'd0, r_div};
      default: Dout = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_device.sv
// Bench for uart_tx_device: frame-level reference model compared every cycle, plus literal timing checks.
module tb_uart_tx_device;
  localparam int BAUD  = 434;
  localparam int DEPTH = 4;

  logic        clk      = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [7:0]  Addr     = 8'h00;
  logic        WE       = 1'b0;
  logic [31:0] Din      = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: a byte queue and the current frame as a 10-entry bit array with per-bit timing.
  logic [7:0]  m_q[$];
  logic        m_ovf    = 1'b0;
  logic        m_irq_en = 1'b0;
  logic        m_active = 1'b0;
  logic        m_irq    = 1'b0;
  logic [15:0] m_div    = 16'(BAUD);
  logic [9:0]  m_bits   = 10'h3FF;
  int          m_pos    = 0;
  int          m_rem    = 0;

  uart_tx_device #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .Addr     (Addr),
    .WE       (WE),
    .Din      (Din),
    .Dout     (Dout),
    .IRQ      (IRQ),
    .txd      (txd)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_txd();
    return m_active ? m_bits[m_pos] : 1'b1;
  endfunction

  function automatic logic [31:0] m_dout(input logic [7:0] a);
    logic [31:0] d;
    d = 32'd0;
    case (a[3:2])
      2'd1: d = {27'd0, m_ovf, m_irq_en, m_active, (m_q.size() == DEPTH), (m_q.size() == 0)};
      2'd2: d = {31'd0, m_irq_en};
      2'd3: d = {16'd0, m_div};
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_irq_en = 1'b0; m_active = 1'b0; m_irq = 1'b0;
    m_div = 16'(BAUD); m_pos = 0; m_rem = 0;
  endtask

  task automatic model_step();
    logic e_old, b_old, ie_old, start;
    logic [15:0] d_old;
    logic [7:0] b;
    e_old = (m_q.size() == 0); b_old = m_active; ie_old = m_irq_en; d_old = m_div;
    m_irq = ie_old && e_old && !b_old;
    start = 1'b0;
    if (b_old) begin
      if (m_rem > 0) m_rem--;
      else if (m_pos < 9) begin m_pos++; m_rem = int'(d_old) - 1; end
      else if (!e_old) start = 1'b1;
      else m_active = 1'b0;
    end else if (!e_old) start = 1'b1;
    if (start) begin
      b = m_q.pop_front();
      m_bits = {1'b1, b, 1'b0};
      m_pos = 0; m_rem = int'(d_old) - 1; m_active = 1'b1;
    end
    if (WE) begin
      case (Addr[3:2])
        2'd0: if (m_q.size() < DEPTH) m_q.push_back(Din[7:0]); else m_ovf = 1'b1;
        2'd1: if (Din[4]) m_ovf = 1'b0;
        2'd2: m_irq_en = Din[0];
        default: m_div = (Din[15:0] < 16'd2) ? 16'd2 : Din[15:0];
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge sys_rstn);
    if (!sys_rstn) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("txd", 32'(txd), 32'(m_txd()));
      check("irq", 32'(IRQ), 32'(m_irq));
      check("dout", Dout, m_dout(Addr));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // All helpers start and end at 1 ns after a rising edge; the write lands on the next edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    Addr = a; WE = 1'b1; Din = d;
    @(posedge clk); #1;
    WE = 1'b0; Addr = 8'h04; Din = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    Addr = a;
    @(negedge clk);
    check(name, Dout, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [9:0]  seq;
    logic        s_txd[0:41];
    logic        s_irq[0:23];
    logic [31:0] r32;
    logic [7:0]  a;
    int n0, ones, zeros, op;
    bit done;

    idle(3);
    #2 sys_rstn = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    rd(8'h00, 32'd0, "rst_data");
    rd(8'h04, 32'h01, "rst_status");
    rd(8'h08, 32'd0, "rst_ctrl");
    rd(8'h0C, 32'd434, "rst_div");
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd0);

    // 0xA5 at DIV=4: start, LSB-first data, stop
    wr(8'h0C, 32'd4);
    wr(8'h00, 32'hA5);
    for (int k = 0; k < 42; k++) begin @(negedge clk); s_txd[k] = txd; end
    @(posedge clk); #1;
    seq = 10'b1101001010;
    check("a5_before_fall", 32'(s_txd[0]), 32'd1);
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < 4; j++)
        check("a5_bit", 32'(s_txd[1 + 4*b + j]), 32'(seq[b]));
    check("a5_after_frame", 32'(s_txd[41]), 32'd1);

    // burst of six bytes at DIV=2 into a 4-deep FIFO
    wr(8'h0C, 32'd2);
    wr(8'h00, 32'h11);
    n0 = cyc;
    wr(8'h00, 32'h22); wr(8'h00, 32'h33); wr(8'h00, 32'h44); wr(8'h00, 32'h55);
    wr(8'h00, 32'h66);
    rd(8'h04, 32'h16, "ovf_set");
    wr(8'h04, 32'h10);
    rd(8'h04, 32'h06, "ovf_clear");
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!Dout[2]) done = 1'b1;
    end
    check("burst_len", 32'(cyc - n0), 32'd101);
    @(posedge clk); #1;

    // interrupt on drain
    wr(8'h00, 32'h00);
    wr(8'h08, 32'h01);
    for (int k = 1; k < 24; k++) begin @(negedge clk); s_irq[k] = IRQ; end
    ones = 0;
    for (int k = 1; k < 22; k++) if (s_irq[k]) ones++;
    check("irq_low_in_frame", 32'(ones), 32'd0);
    check("irq_rise", 32'(s_irq[22]), 32'd1);
    @(posedge clk); #1;
    wr(8'h08, 32'h00);
    @(negedge clk);
    check("irq_hold", 32'(IRQ), 32'd1);
    @(negedge clk);
    check("irq_fall", 32'(IRQ), 32'd0);
    @(posedge clk); #1;

    // DIV change mid-bit
    wr(8'h0C, 32'd8);
    wr(8'h00, 32'hFF);
    idle(8);
    @(negedge clk);
    check("div_start_last", 32'(txd), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("div_bit0_first", 32'(txd), 32'd1);
    @(posedge clk); #1;
    idle(1);
    wr(8'h0C, 32'd3);
    idle(28);
    @(negedge clk);
    check("div_busy_end", 32'(Dout[2]), 32'd1);
    @(negedge clk);
    check("div_idle", 32'(Dout[2]), 32'd0);
    @(posedge clk); #1;
    wr(8'h0C, 32'd0);
    rd(8'h0C, 32'd2, "div_min");

    // reset during DATA with two bytes queued
    wr(8'h0C, 32'd4);
    wr(8'h00, 32'h00); wr(8'h00, 32'h00); wr(8'h00, 32'h00);
    idle(10);
    #1;
    check("pre_rst_txd", 32'(txd), 32'd0);
    check("pre_rst_status", Dout, 32'h04);
    sys_rstn = 1'b0;
    #1;
    check("rst_async_txd", 32'(txd), 32'd1);
    repeat (2) @(negedge clk);
    #2 sys_rstn = 1'b1;
    @(posedge clk); #1;
    rd(8'h04, 32'h01, "post_rst_status");
    zeros = 0;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (!txd) zeros++; end
    check("no_frame_after_rst", 32'(zeros), 32'd0);
    @(posedge clk); #1;

    // randomized traffic against the model
    wr(8'h0C, 32'($urandom_range(2, 5)));
    for (int i = 0; i < 300; i++) begin
      r32 = $urandom;
      a = 8'($urandom);
      op = int'($urandom_range(0, 9));
      if (op < 5) begin
        a[3:2] = 2'd0; wr(a, r32);
      end else if (op == 5) begin
        Addr = a; idle(1);
      end else if (op == 6) begin
        a[3:2] = 2'd2; wr(a, r32);
      end else if (op == 7) begin
        a[3:2] = 2'd1; wr(a, r32);
      end else if (op == 8) begin
        a[3:2] = 2'd3; wr(a, {r32[31:16], 16'($urandom_range(0, 5))});
      end else begin
        Addr = a; idle(int'($urandom_range(1, 40)));
      end
    end
    Addr = 8'h04;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (Dout[2:0] == 3'b001) done = 1'b1;
    end
    check("drain", {29'd0, Dout[2:0]}, 32'h1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
